// File: rtl/control_unit_mc_pkg.sv
// Shared encodings for the multi-cycle main decoder: opcodes, ALU op codes, FSM states.
package control_unit_mc_pkg;

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_R_TYPE = 3'b010;
    localparam logic [2:0] ALU_MUL    = 3'b011;

    typedef enum logic [1:0] {
        ST_DECODE   = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_MUL_WB   = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [6:0] op, input logic [6:0] f7);
        return (op == OP_ALU_R) && (f7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/cu_mul_timer.sv
// Loadable down-counter timing the fixed multiplier latency; 'last' marks the final wait cycle.
module cu_mul_timer #(
    parameter int MUL_CYCLES = 4,
    localparam int CW = $clog2(MUL_CYCLES + 1)
) (
    input  logic clk,
    input  logic arst_n,
    input  logic load,
    input  logic en,
    output logic last
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MUL_CYCLES);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CW'(1));

endmodule

// File: rtl/control_unit_mc.sv
// Main decoder with stall-based sequencing of multi-cycle MUL ops (DECODE -> MUL_WAIT -> MUL_WB).
module control_unit_mc
    import control_unit_mc_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter bit USE_DONE   = 1'b0,
    parameter int ALU_OP_W   = 3
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                instr_valid,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                flush,
    input  logic                mul_done,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                mem_2_reg,
    output logic                mem_read,
    output logic                mem_write,
    output logic                branch,
    output logic                jump,
    output logic                reg_write,
    output logic                mul_start,
    output logic                stall,
    output logic [2:0]          mul_op
);

    state_t state, state_nxt;
    logic   launch;
    logic   timer_last;
    logic   wait_over;

    assign launch    = (state == ST_DECODE) && instr_valid && !flush && is_mul(opcode, funct7);
    assign wait_over = USE_DONE ? mul_done : timer_last;

    cu_mul_timer #(.MUL_CYCLES(MUL_CYCLES)) u_timer (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (launch),
        .en     ((state == ST_MUL_WAIT) && !USE_DONE),
        .last   (timer_last)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= ST_DECODE;
            mul_op <= 3'b000;
        end else begin
            state <= state_nxt;
            if (launch) begin
                mul_op <= funct3;
            end
        end
    end

    // flush wins over mul_done / counter expiry so a killed MUL never writes back
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DECODE:   if (launch) state_nxt = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (flush)          state_nxt = ST_DECODE;
                else if (wait_over) state_nxt = ST_MUL_WB;
            end
            ST_MUL_WB:   state_nxt = ST_DECODE;
            default:     state_nxt = ST_DECODE;
        endcase
    end

    always_comb begin
        alu_op    = '0;
        alu_src   = 1'b0;
        mem_2_reg = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        reg_write = 1'b0;
        mul_start = 1'b0;
        stall     = 1'b0;
        if (arst_n) begin
            case (state)
                ST_DECODE: begin
                    if (launch) begin
                        alu_op    = ALU_OP_W'(ALU_MUL);
                        mul_start = 1'b1;
                        stall     = 1'b1;
                    end else if (instr_valid && !flush) begin
                        case (opcode)
                            OP_ALU_R: begin
                                alu_op    = ALU_OP_W'(ALU_R_TYPE);
                                reg_write = 1'b1;
                            end
                            OP_ALU_I: begin
                                alu_op    = ALU_OP_W'(ALU_ADD);
                                alu_src   = 1'b1;
                                reg_write = 1'b1;
                            end
                            OP_BEQ: begin
                                alu_op = ALU_OP_W'(ALU_SUB);
                                branch = 1'b1;
                            end
                            OP_JAL: begin
                                jump      = 1'b1;
                                reg_write = 1'b1;
                            end
                            OP_LOAD: begin
                                alu_op    = ALU_OP_W'(ALU_ADD);
                                alu_src   = 1'b1;
                                mem_read  = 1'b1;
                                mem_2_reg = 1'b1;
                                reg_write = 1'b1;
                            end
                            OP_STORE: begin
                                alu_op    = ALU_OP_W'(ALU_ADD);
                                alu_src   = 1'b1;
                                mem_write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL_WAIT: begin
                    alu_op = ALU_OP_W'(ALU_MUL);
                    stall  = 1'b1;
                end
                ST_MUL_WB: begin
                    alu_op    = ALU_OP_W'(ALU_MUL);
                    reg_write = !flush;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench: three decoder instances (fixed latency 4, mul_done-driven, fixed latency 1) share stimulus.
module tb_control_unit_mc;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       flush = 1'b0;
    logic       mul_done = 1'b0;

    logic [2:0] alu_op0, alu_op1, alu_op2;
    logic [8:0] f0, f1, f2;
    logic [2:0] mop0, mop1, mop2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    control_unit_mc #(.MUL_CYCLES(4), .USE_DONE(1'b0), .ALU_OP_W(3)) u0 (
        .clk(clk), .arst_n(arst_n), .instr_valid(instr_valid), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .flush(flush), .mul_done(mul_done),
        .alu_op(alu_op0), .alu_src(f0[8]), .mem_2_reg(f0[7]), .mem_read(f0[6]),
        .mem_write(f0[5]), .branch(f0[4]), .jump(f0[3]), .reg_write(f0[2]),
        .mul_start(f0[1]), .stall(f0[0]), .mul_op(mop0));

    control_unit_mc #(.MUL_CYCLES(4), .USE_DONE(1'b1), .ALU_OP_W(3)) u1 (
        .clk(clk), .arst_n(arst_n), .instr_valid(instr_valid), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .flush(flush), .mul_done(mul_done),
        .alu_op(alu_op1), .alu_src(f1[8]), .mem_2_reg(f1[7]), .mem_read(f1[6]),
        .mem_write(f1[5]), .branch(f1[4]), .jump(f1[3]), .reg_write(f1[2]),
        .mul_start(f1[1]), .stall(f1[0]), .mul_op(mop1));

    control_unit_mc #(.MUL_CYCLES(1), .USE_DONE(1'b0), .ALU_OP_W(3)) u2 (
        .clk(clk), .arst_n(arst_n), .instr_valid(instr_valid), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .flush(flush), .mul_done(mul_done),
        .alu_op(alu_op2), .alu_src(f2[8]), .mem_2_reg(f2[7]), .mem_read(f2[6]),
        .mem_write(f2[5]), .branch(f2[4]), .jump(f2[3]), .reg_write(f2[2]),
        .mul_start(f2[1]), .stall(f2[0]), .mul_op(mop2));

    // {alu_op, alu_src, mem_2_reg, mem_read, mem_write, branch, jump, reg_write, mul_start, stall}
    wire [11:0] c0 = {alu_op0, f0};
    wire [11:0] c1 = {alu_op1, f1};
    wire [11:0] c2 = {alu_op2, f2};

    localparam logic [11:0] E_NOP   = 12'b000_000000000;
    localparam logic [11:0] E_START = 12'b011_000000011;
    localparam logic [11:0] E_WAIT  = 12'b011_000000001;
    localparam logic [11:0] E_WB    = 12'b011_000000100;
    localparam logic [11:0] E_ALUR  = 12'b010_000000100;
    localparam logic [11:0] E_ALUI  = 12'b000_100000100;
    localparam logic [11:0] E_BEQ   = 12'b001_000010000;
    localparam logic [11:0] E_JAL   = 12'b000_000001100;
    localparam logic [11:0] E_LOAD  = 12'b000_111000100;
    localparam logic [11:0] E_STORE = 12'b000_100100000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        instr_valid = 1'b0; flush = 1'b0; mul_done = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic drive_mul(input logic [2:0] f3);
        instr_valid = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = f3;
    endtask

    task automatic test_reset();
        do_reset();
        drive_mul(3'b101);
        #1;
        tick();
        opcode = 7'b0000011; funct7 = 7'd0;
        #2;
        arst_n = 1'b0;
        #1;
        total++;
        if (c0 !== E_NOP) $display("FAIL reset_outputs actual=%b required=%b", c0, E_NOP);
        else passed++;
        total++;
        if (mop0 !== 3'b000) $display("FAIL reset_mul_op actual=%b required=000", mop0);
        else passed++;
        tick();
        arst_n = 1'b1;
        #1;
        tick();
        total++;
        if (c0 !== E_LOAD) $display("FAIL reset_release_load actual=%b required=%b", c0, E_LOAD);
        else passed++;
        instr_valid = 1'b0;
    endtask

    task automatic test_base_set();
        logic [6:0]  ops  [7] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                                  7'b0000011, 7'b0100011, 7'b1111111};
        logic [11:0] exps [7] = '{E_ALUR, E_ALUI, E_BEQ, E_JAL, E_LOAD, E_STORE, E_NOP};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            instr_valid = 1'b1; opcode = ops[i]; funct7 = 7'd0; funct3 = 3'd0;
            #1;
            total++;
            if (c0 !== exps[i]) $display("FAIL base_op%0d op=%b actual=%b required=%b", i, ops[i], c0, exps[i]);
            else passed++;
            tick();
        end
        opcode = 7'b0000011; instr_valid = 1'b0;
        #1;
        total++;
        if (c0 !== E_NOP) $display("FAIL base_invalid actual=%b required=%b", c0, E_NOP);
        else passed++;
        instr_valid = 1'b1; flush = 1'b1;
        #1;
        total++;
        if (c0 !== E_NOP) $display("FAIL base_flush actual=%b required=%b", c0, E_NOP);
        else passed++;
        flush = 1'b0; instr_valid = 1'b0;
    endtask

    task automatic test_mul_fixed();
        do_reset();
        drive_mul(3'b011);
        #1;
        total++;
        if (c0 !== E_START) $display("FAIL mul_T actual=%b required=%b", c0, E_START);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (c0 !== E_WAIT) $display("FAIL mul_wait_T+%0d actual=%b required=%b", k, c0, E_WAIT);
            else passed++;
        end
        total++;
        if (mop0 !== 3'b011) $display("FAIL mul_op actual=%b required=011", mop0);
        else passed++;
        tick();
        total++;
        if (c0 !== E_WB) $display("FAIL mul_wb_T+5 actual=%b required=%b", c0, E_WB);
        else passed++;
        instr_valid = 1'b0;
        tick();
        total++;
        if (c0 !== E_NOP) $display("FAIL mul_after_T+6 actual=%b required=%b", c0, E_NOP);
        else passed++;
    endtask

    task automatic test_mul_done();
        do_reset();
        instr_valid = 1'b1; opcode = 7'b0010011; funct7 = 7'd0; mul_done = 1'b1;
        #1;
        total++;
        if (c1 !== E_ALUI) $display("FAIL done_in_decode actual=%b required=%b", c1, E_ALUI);
        else passed++;
        tick();
        mul_done = 1'b0;
        drive_mul(3'b001);
        #1;
        total++;
        if (c1 !== E_START) $display("FAIL done_T actual=%b required=%b", c1, E_START);
        else passed++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 7) mul_done = 1'b1;
            #1;
            total++;
            if (c1 !== E_WAIT) $display("FAIL done_wait_T+%0d actual=%b required=%b", k, c1, E_WAIT);
            else passed++;
        end
        tick();
        mul_done = 1'b0;
        instr_valid = 1'b0;
        #1;
        total++;
        if (c1 !== E_WB) $display("FAIL done_wb_T+8 actual=%b required=%b", c1, E_WB);
        else passed++;
        total++;
        if (mop1 !== 3'b001) $display("FAIL done_mul_op actual=%b required=001", mop1);
        else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        drive_mul(3'b000);
        #1;
        tick();
        tick();
        flush = 1'b1;
        #1;
        total++;
        if (c0 !== E_WAIT) $display("FAIL flush_T+2 actual=%b required=%b", c0, E_WAIT);
        else passed++;
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            #1;
            total++;
            if (c0 !== E_NOP) $display("FAIL flush_T+%0d actual=%b required=%b", k, c0, E_NOP);
            else passed++;
            tick();
        end
        do_reset();
        drive_mul(3'b010);
        #1;
        tick();
        flush = 1'b1; mul_done = 1'b1;
        #1;
        total++;
        if (c1 !== E_WAIT) $display("FAIL flushdone_T+1 actual=%b required=%b", c1, E_WAIT);
        else passed++;
        tick();
        flush = 1'b0; mul_done = 1'b0; instr_valid = 1'b0;
        #1;
        total++;
        if (c1 !== E_NOP) $display("FAIL flushdone_T+2 actual=%b required=%b", c1, E_NOP);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] pat [3] = '{E_START, E_WAIT, E_WB};
        do_reset();
        drive_mul(3'b100);
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) funct3 = 3'(4 + i / 3);
            #1;
            total++;
            if (c2 !== pat[i % 3]) $display("FAIL b2b_cycle%0d actual=%b required=%b", i, c2, pat[i % 3]);
            else passed++;
            if (i % 3 == 1) begin
                total++;
                if (mop2 !== 3'(4 + i / 3)) $display("FAIL b2b_mul_op%0d actual=%b required=%b", i, mop2, 3'(4 + i / 3));
                else passed++;
            end
            tick();
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_base_set();
        test_mul_fixed();
        test_mul_done();
        test_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
